// File: rtl/axis_pkg.sv
// ----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream broadcast slice.
//   AXIS_MAX_PORTS   largest fan-out the broadcast supports
//   axis_keep_width  tkeep width for a given tdata width (one bit per byte)
//   `AXIS_SLICE      selects port idx of a flattened per-port bus of width w
// ----------------------------------------------------------------------------

`ifndef AXIS_PKG_SLICE_MACROS
`define AXIS_PKG_SLICE_MACROS
`define AXIS_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package axis_pkg;

    localparam int AXIS_MAX_PORTS = 16;

    // One tkeep bit per tdata byte
    function automatic int axis_keep_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/axis_bcast_slot.sv
// ----------------------------------------------------------------------------
// axis_bcast_slot
// One-beat holding register for the broadcast: stores tdata/tkeep/tlast and
// a valid flag. Load wins over clear so a beat can be retired and replaced in
// the same cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_i            capture data_i/keep_i/last_i and set valid
//   clear_i           drop valid (ignored when load_i is high)
//   data_i/keep_i/last_i   incoming beat
//   valid_o           a beat is held
//   data_o/keep_o/last_o   held beat
// ----------------------------------------------------------------------------

module axis_bcast_slot
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = axis_keep_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [KEEP_WIDTH-1:0] keep_i,
    input  logic                  last_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [KEEP_WIDTH-1:0] keep_o,
    output logic                  last_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic                  last_q;

    // Valid flag: a reload in the retiring cycle keeps the slot occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload only changes on load so a stalled consumer sees stable data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            keep_q <= keep_i;
            last_q <= last_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axis_broadcast.sv
// ----------------------------------------------------------------------------
// axis_broadcast
// AXI-Stream 1-to-N fan-out with a one-beat holding register. Every enabled
// output takes each beat independently; a per-port "sent" bit stops an output
// from seeing the same beat twice while slower outputs catch up. The output
// enable mask is captured on the first beat of each packet.
// Optional feature macro: AXIS_BCAST_PKT_CNT_EN enables the completed-packet
// counter on pkt_count; without it pkt_count is tied to zero.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_axis_tdata/tkeep/tvalid/tlast, s_axis_tready   upstream stream
//   port_en                      output enable mask, sampled per packet
//   m_axis_tdata/tkeep           flattened, port i at [i*W +: W]
//   m_axis_tvalid/tready/tlast   one bit per output port
//   pkt_count                    completed packets (dropped ones included)
// ----------------------------------------------------------------------------

module axis_broadcast
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = axis_keep_width(DATA_WIDTH),
    parameter int NUM_PORTS  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [NUM_PORTS-1:0]            port_en,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_PORTS*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [NUM_PORTS-1:0]            m_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            m_axis_tready,
    output logic [NUM_PORTS-1:0]            m_axis_tlast,
    output logic [31:0]                     pkt_count
);

    if (NUM_PORTS < 1 || NUM_PORTS > AXIS_MAX_PORTS) begin : gBadPorts
        $error("axis_broadcast: NUM_PORTS out of range");
    end
    if (DATA_WIDTH % 8 != 0) begin : gBadWidth
        $error("axis_broadcast: DATA_WIDTH must be a multiple of 8");
    end

    logic                  bufValid;
    logic [DATA_WIDTH-1:0] bufData;
    logic [KEEP_WIDTH-1:0] bufKeep;
    logic                  bufLast;

    logic [NUM_PORTS-1:0]  sent_q;
    logic [NUM_PORTS-1:0]  sent_d;
    logic [NUM_PORTS-1:0]  maskAct_q;
    logic                  inPkt_q;

    logic [NUM_PORTS-1:0]  handshake;
    logic [NUM_PORTS-1:0]  portDone;
    logic                  done;
    logic                  accept;

    // A port is finished with the held beat if it is masked off, already
    // took it, or is taking it right now. With an empty mask every port is
    // finished, so a dropped beat retires the cycle after it is loaded.
    assign handshake     = m_axis_tvalid & m_axis_tready;
    assign portDone      = ~maskAct_q | sent_q | handshake;
    assign done          = bufValid & (&portDone);
    assign s_axis_tready = ~bufValid | done;
    assign accept        = s_axis_tvalid & s_axis_tready;

    axis_bcast_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) uSlot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .clear_i (done),
        .data_i  (s_axis_tdata),
        .keep_i  (s_axis_tkeep),
        .last_i  (s_axis_tlast),
        .valid_o (bufValid),
        .data_o  (bufData),
        .keep_o  (bufKeep),
        .last_o  (bufLast)
    );

    // Sent bits accumulate handshakes until the beat retires; a reload in
    // the retiring cycle therefore starts with a clean slate.
    always_comb begin
        sent_d = sent_q | handshake;
        if (done) begin
            sent_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    // The mask is only captured on a packet's first beat, so port_en
    // changes inside a packet wait until the next packet starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maskAct_q <= '0;
            inPkt_q   <= 1'b0;
        end else if (accept) begin
            if (!inPkt_q) begin
                maskAct_q <= port_en;
            end
            inPkt_q <= ~s_axis_tlast;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : gPort
        assign `AXIS_SLICE(m_axis_tdata, i, DATA_WIDTH) = bufData;
        assign `AXIS_SLICE(m_axis_tkeep, i, KEEP_WIDTH) = bufKeep;
    end

    assign m_axis_tlast  = {NUM_PORTS{bufLast}};
    assign m_axis_tvalid = {NUM_PORTS{bufValid}} & maskAct_q & ~sent_q;

`ifdef AXIS_BCAST_PKT_CNT_EN
    logic [31:0] pktCount_q;

    // Counts a packet when its last beat retires; wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pktCount_q <= 32'd0;
        end else if (done && bufLast) begin
            pktCount_q <= pktCount_q + 32'd1;
        end
    end

    assign pkt_count = pktCount_q;
`else
    assign pkt_count = 32'd0;
`endif

endmodule

// File: tb/tb_axis_broadcast.sv
// ----------------------------------------------------------------------------
// tb_axis_broadcast
// Directed bench for axis_broadcast with NUM_PORTS=3: full-rate packet,
// stalled port, mid-packet mask change, dropped packet, reset mid-packet and
// a long run with random valid gaps and random output readiness. Output
// beats are captured per port and compared with a reference model of the
// mask rule kept by the bench.
// ----------------------------------------------------------------------------

module tb_axis_broadcast;

    localparam int NP = 3;
    localparam int DW = 32;
    localparam int KW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    s_axis_tdata;
    logic [KW-1:0]    s_axis_tkeep;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [NP-1:0]    port_en;
    logic [NP*DW-1:0] m_axis_tdata;
    logic [NP*KW-1:0] m_axis_tkeep;
    logic [NP-1:0]    m_axis_tvalid;
    logic [NP-1:0]    m_axis_tready;
    logic [NP-1:0]    m_axis_tlast;
    logic [31:0]      pkt_count;

    logic [NP-1:0]    readyFix;
    logic [NP-1:0]    readyRand = '0;
    logic             randomReady;

    int checks   = 0;
    int failures = 0;

    logic [36:0]   expQ [NP][$];
    logic [36:0]   gotQ [NP][$];
    logic          modelInPkt;
    logic [NP-1:0] modelMask;
    int            expPkts;
    int            validSeen;

    logic [NP-1:0] stallPrev;
    logic [36:0]   stallBeat [NP];

    assign m_axis_tready = randomReady ? readyRand : readyFix;

    axis_broadcast #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .port_en       (port_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    // Output readiness for the random phase changes just after each edge
    always @(posedge clk) begin
        #1;
        readyRand = NP'($urandom_range(0, (1 << NP) - 1));
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] portBeat(input int i);
        return {m_axis_tlast[i], m_axis_tkeep[i*KW +: KW], m_axis_tdata[i*DW +: DW]};
    endfunction

    function automatic logic [31:0] expCount();
`ifdef AXIS_BCAST_PKT_CNT_EN
        return 32'(expPkts);
`else
        return 32'd0;
`endif
    endfunction

    // Reference model: mask taken on a packet's first beat, beat goes to
    // every port in that mask
    function automatic void recordBeat(input logic [31:0] d, input logic [3:0] k,
                                       input logic last, input logic [NP-1:0] en);
        if (!modelInPkt) modelMask = en;
        modelInPkt = !last;
        for (int i = 0; i < NP; i++) begin
            if (modelMask[i]) expQ[i].push_back({last, k, d});
        end
        if (last) expPkts++;
    endfunction

    // Capture every output handshake and check that stalled ports hold
    // their beat steady until taken
    always @(negedge clk) begin
        if (rst) begin
            stallPrev = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (stallPrev[i]) begin
                    checkOutput($sformatf("p%0d_stall_valid", i), 64'(m_axis_tvalid[i]), 64'd1);
                    checkOutput($sformatf("p%0d_stall_beat", i), 64'(portBeat(i)), 64'(stallBeat[i]));
                end
                if (m_axis_tvalid[i] && m_axis_tready[i]) gotQ[i].push_back(portBeat(i));
                stallPrev[i] = m_axis_tvalid[i] & ~m_axis_tready[i];
                stallBeat[i] = portBeat(i);
            end
            if (|m_axis_tvalid) validSeen++;
        end
    end

    // Drive one beat and hold it until accepted; starts and ends 1 unit
    // after a rising edge
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic last,
                                 input logic [NP-1:0] en, output int waited);
        bit ok;
        ok            = 1'b0;
        waited        = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        port_en       = en;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (s_axis_tready) ok = 1'b1;
            else waited++;
        end
        if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        if (ok) recordBeat(d, k, last, en);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compareQueues(input string name);
        int n;
        for (int i = 0; i < NP; i++) begin
            checkOutput($sformatf("%s_p%0d_beats", name, i), 64'(gotQ[i].size()), 64'(expQ[i].size()));
            n = (gotQ[i].size() < expQ[i].size()) ? gotQ[i].size() : expQ[i].size();
            for (int j = 0; j < n; j++) begin
                checkOutput($sformatf("%s_p%0d_beat%0d", name, i, j), 64'(gotQ[i][j]), 64'(expQ[i][j]));
            end
            gotQ[i].delete();
            expQ[i].delete();
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        port_en       = '0;
        readyFix      = '1;
        randomReady   = 1'b0;
        modelInPkt    = 1'b0;
        modelMask     = '0;
        expPkts       = 0;
        validSeen     = 0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst_ready", 64'(s_axis_tready), 64'd1);
        checkOutput("rst_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idleCycles(1);

        // Test 1: full-rate 4-beat packet to all ports
        $display("[TB] test 1: full-rate packet");
        for (int b = 0; b < 4; b++) begin
            s_axis_tdata  = 32'hA0 + 32'(b);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (b == 3);
            port_en       = 3'b111;
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("t1_ready%0d", b), 64'(s_axis_tready), 64'd1);
            if (b > 0) begin
                checkOutput($sformatf("t1_valid%0d", b), 64'(m_axis_tvalid), 64'h7);
                for (int i = 0; i < NP; i++) begin
                    checkOutput($sformatf("t1_p%0d_data%0d", i, b), 64'(m_axis_tdata[i*DW +: DW]),
                                64'h9F + 64'(b));
                end
                checkOutput($sformatf("t1_last%0d", b), 64'(m_axis_tlast), 64'd0);
            end
            @(posedge clk);
            #1;
            recordBeat(32'hA0 + 32'(b), 4'hF, b == 3, 3'b111);
        end
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        checkOutput("t1_valid_last", 64'(m_axis_tvalid), 64'h7);
        checkOutput("t1_data_last", 64'(m_axis_tdata[2*DW +: DW]), 64'hA3);
        checkOutput("t1_tlast", 64'(m_axis_tlast), 64'h7);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t1_idle_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t1_count", 64'(pkt_count), 64'(expCount()));
        @(posedge clk);
        #1;
        compareQueues("t1");

        // Test 2: port 1 stalls for three cycles on B0
        $display("[TB] test 2: stalled port");
        readyFix      = 3'b101;
        s_axis_tdata  = 32'hB0;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        port_en       = 3'b111;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        checkOutput("t2_accept", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        recordBeat(32'hB0, 4'hF, 1'b0, 3'b111);
        @(negedge clk);
        checkOutput("t2_c1_valid", 64'(m_axis_tvalid), 64'h7);
        checkOutput("t2_c1_ready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t2_c2_valid", 64'(m_axis_tvalid), 64'h2);
        checkOutput("t2_c2_ready", 64'(s_axis_tready), 64'd0);
        checkOutput("t2_c2_data", 64'(m_axis_tdata[DW +: DW]), 64'hB0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t2_c3_valid", 64'(m_axis_tvalid), 64'h2);
        checkOutput("t2_c3_ready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        readyFix = 3'b111;
        @(negedge clk);
        checkOutput("t2_c4_valid", 64'(m_axis_tvalid), 64'h2);
        checkOutput("t2_c4_ready", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t2_c5_valid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'hB1, 4'h3, 1'b1, 3'b111, w);
        idleCycles(2);
        compareQueues("t2");

        // Test 3: mask flipped mid-packet, then a packet for port 1 only
        $display("[TB] test 3: mask sampled on first beat");
        applyStimulus(32'hC0, 4'hF, 1'b0, 3'b101, w);
        applyStimulus(32'hC1, 4'hF, 1'b0, 3'b010, w);
        applyStimulus(32'hC2, 4'h1, 1'b1, 3'b010, w);
        applyStimulus(32'hD0, 4'hF, 1'b0, 3'b010, w);
        applyStimulus(32'hD1, 4'hF, 1'b1, 3'b101, w);
        idleCycles(3);
        compareQueues("t3");

        // Test 4: empty mask drops the packet at full rate
        $display("[TB] test 4: dropped packet");
        validSeen = 0;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(32'hE0 + 32'(b), 4'hF, b == 2, 3'b000, w);
            checkOutput($sformatf("t4_wait%0d", b), 64'(w), 64'd0);
        end
        idleCycles(2);
        checkOutput("t4_no_valid", 64'(validSeen), 64'd0);
        checkOutput("t4_count", 64'(pkt_count), 64'(expCount()));
        compareQueues("t4");

        // Test 5: reset while beat 2 of a packet is held
        $display("[TB] test 5: reset mid-packet");
        applyStimulus(32'hF0, 4'hF, 1'b0, 3'b111, w);
        applyStimulus(32'hF1, 4'hF, 1'b0, 3'b111, w);
        readyFix = 3'b000;
        @(negedge clk);
        checkOutput("t5_held", 64'(m_axis_tvalid), 64'h7);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_async_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t5_async_ready", 64'(s_axis_tready), 64'd1);
        for (int i = 0; i < NP; i++) void'(expQ[i].pop_back());
        modelInPkt = 1'b0;
        expPkts    = 0;
        repeat (2) @(posedge clk);
        #2;
        rst      = 1'b0;
        readyFix = 3'b111;
        @(negedge clk);
        checkOutput("t5_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h60, 4'hF, 1'b1, 3'b001, w);
        idleCycles(2);
        compareQueues("t5");

        // Test 6: random gaps, lengths, masks and output readiness
        $display("[TB] test 6: random traffic");
        randomReady = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idleCycles(1);
                applyStimulus($urandom, 4'($urandom_range(0, 15)), b == len - 1,
                              NP'($urandom_range(0, (1 << NP) - 1)), w);
            end
        end
        randomReady = 1'b0;
        readyFix    = 3'b111;
        idleCycles(4);
        compareQueues("t6");
        checkOutput("t6_count", 64'(pkt_count), 64'(expCount()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
